trace_compare_unit: RTL and testbench

// - Consumer end of the CPU trace debug interface (debug_wb_pc / _rf_we / _rf_wnum / _rf_wdata).
// - Golden write-back records arrive on a valid/ready stream and are buffered in an internal FIFO.
// - Each register write-back committed by the core is checked against the FIFO head.
// - Reports PASS/FAIL, error statistics and the first mismatch; sits beside mycpu_top in the SoC/bench.

---
 rtl/trace_compare_unit_if.sv | 30 +++
 rtl/trace_compare_unit.sv | 187 ++++++++++++++++++
 tb/tb_trace_compare_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_compare_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : trace_compare_unit_if
// Brief   : Core trace write-back bus plus golden-record valid/ready stream.
// Revision: 1.0
// ============================================================================
interface trace_compare_unit_if;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;

    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output ref_valid, ref_pc, ref_wnum, ref_wdata,
        input  ref_ready
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  ref_valid, ref_pc, ref_wnum, ref_wdata,
        output ref_ready
    );
endinterface
`default_nettype wire

// File: rtl/trace_compare_unit.sv
`default_nettype none
// ============================================================================
// Module  : trace_compare_unit
// Brief   : Checks committed register write-backs against buffered golden records.
// Revision: 1.0
// ============================================================================
module trace_compare_unit #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] START_PC    = 32'h1c00_0000,
    parameter logic [31:0] END_PC      = 32'h1c00_0100,
    parameter logic [15:0] TIMEOUT     = 16'hffff,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    trace_compare_unit_if.slave tif,
    output logic [1:0]          state,
    output logic [1:0]          fail_code,
    output logic [15:0]         err_cnt,
    output logic [31:0]         commit_cnt,
    output logic [31:0]         mism_pc,
    output logic [31:0]         mism_got,
    output logic [31:0]         mism_exp
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_UNDERRUN = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [4:0]    fifo_wnum_q  [FIFO_DEPTH];
    logic [31:0]   fifo_wdata_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;

    logic [1:0]  state_q, state_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;
    logic [31:0] mism_pc_q, mism_pc_d;
    logic [31:0] mism_got_q, mism_got_d;
    logic [31:0] mism_exp_q, mism_exp_d;
    logic [15:0] tmo_q, tmo_d;

    logic        fifo_full, fifo_empty, active;
    logic        push, commit, pop;
    logic        byte_mis, mismatch, underrun, timeout, err;
    logic [1:0]  err_code;
    logic [31:0] head_pc, head_wdata;
    logic [4:0]  head_wnum;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign active     = (state_q == S_IDLE) || (state_q == S_RUN);

    assign tif.ref_ready = !reset && !fifo_full && active;
    assign push          = tif.ref_valid && tif.ref_ready;

    assign commit = (state_q == S_RUN) && (|tif.debug_wb_rf_we) && (tif.debug_wb_rf_wnum != 5'd0);
    assign pop    = commit && !fifo_empty;

    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_wnum  = fifo_wnum_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

    // Only bytes actually written by the core take part in the data compare.
    always_comb begin
        byte_mis = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tif.debug_wb_rf_we[i] &&
                (tif.debug_wb_rf_wdata[8*i +: 8] != head_wdata[8*i +: 8])) begin
                byte_mis = 1'b1;
            end
        end
    end

    assign mismatch = pop && ((tif.debug_wb_pc != head_pc) ||
                              (tif.debug_wb_rf_wnum != head_wnum) || byte_mis);
    assign underrun = commit && fifo_empty;
    assign timeout  = (state_q == S_RUN) && !commit && (tmo_q == TIMEOUT - 16'd1);
    assign err_code = timeout  ? FC_TIMEOUT  :
                      underrun ? FC_UNDERRUN :
                      mismatch ? FC_MISMATCH : FC_NONE;
    assign err      = (err_code != FC_NONE);

    always_comb begin
        state_d      = state_q;
        fail_code_d  = fail_code_q;
        err_cnt_d    = err_cnt_q;
        commit_cnt_d = commit_cnt_q;
        mism_pc_d    = mism_pc_q;
        mism_got_d   = mism_got_q;
        mism_exp_d   = mism_exp_q;
        tmo_d        = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (tif.debug_wb_pc == START_PC) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                tmo_d = commit ? 16'd0 : tmo_q + 16'd1;
                if (commit) begin
                    commit_cnt_d = commit_cnt_q + 32'd1;
                end
                if (err) begin
                    if (err_cnt_q != 16'hffff) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (fail_code_q == FC_NONE) begin
                        fail_code_d = err_code;
                        mism_pc_d   = tif.debug_wb_pc;
                        mism_got_d  = tif.debug_wb_rf_wdata;
                        mism_exp_d  = mismatch ? head_wdata : 32'd0;
                    end
                end
                // The END_PC verdict includes any error raised in this same cycle.
                if ((err_code == FC_TIMEOUT) || (err && STOP_ON_ERR)) begin
                    state_d = S_FAIL;
                end else if (tif.debug_wb_pc == END_PC) begin
                    state_d = ((err_cnt_q == 16'd0) && !err) ? S_PASS : S_FAIL;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= tif.ref_pc;
            fifo_wnum_q[wr_ptr_q]  <= tif.ref_wnum;
            fifo_wdata_q[wr_ptr_q] <= tif.ref_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            fail_code_q  <= FC_NONE;
            err_cnt_q    <= 16'd0;
            commit_cnt_q <= 32'd0;
            mism_pc_q    <= 32'd0;
            mism_got_q   <= 32'd0;
            mism_exp_q   <= 32'd0;
            tmo_q        <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q      <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            state_q      <= state_d;
            fail_code_q  <= fail_code_d;
            err_cnt_q    <= err_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            mism_pc_q    <= mism_pc_d;
            mism_got_q   <= mism_got_d;
            mism_exp_q   <= mism_exp_d;
            tmo_q        <= tmo_d;
        end
    end

    assign state      = state_q;
    assign fail_code  = fail_code_q;
    assign err_cnt    = err_cnt_q;
    assign commit_cnt = commit_cnt_q;
    assign mism_pc    = mism_pc_q;
    assign mism_got   = mism_got_q;
    assign mism_exp   = mism_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_compare_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_compare_unit
// Brief   : Vector table, directed corner sequences and a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_trace_compare_unit;

    localparam logic [31:0] START = 32'h1c00_0000;
    localparam logic [31:0] ENDPC = 32'h1c00_0100;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [31:0] rpc;
        logic [4:0]  rwnum;
        logic [31:0] rwdata;
        logic [1:0]  exp_st;
        logic [1:0]  exp_fc;
        logic [31:0] exp_cc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] pc, wdata, rpc, rwdata;
    logic [3:0]  we;
    logic [4:0]  wnum, rwnum;
    logic        rv;

    logic [1:0]  st_a, fc_a, st_b, fc_b;
    logic [15:0] ec_a, ec_b;
    logic [31:0] cc_a, mp_a, mg_a, me_a, cc_b, mp_b, mg_b, me_b;

    trace_compare_unit_if if_a ();
    trace_compare_unit_if if_b ();

    assign if_a.debug_wb_pc = pc;       assign if_b.debug_wb_pc = pc;
    assign if_a.debug_wb_rf_we = we;    assign if_b.debug_wb_rf_we = we;
    assign if_a.debug_wb_rf_wnum = wnum; assign if_b.debug_wb_rf_wnum = wnum;
    assign if_a.debug_wb_rf_wdata = wdata; assign if_b.debug_wb_rf_wdata = wdata;
    assign if_a.ref_valid = rv;         assign if_b.ref_valid = rv;
    assign if_a.ref_pc = rpc;           assign if_b.ref_pc = rpc;
    assign if_a.ref_wnum = rwnum;       assign if_b.ref_wnum = rwnum;
    assign if_a.ref_wdata = rwdata;     assign if_b.ref_wdata = rwdata;

    trace_compare_unit #(.FIFO_DEPTH(8), .START_PC(START), .END_PC(ENDPC),
                         .TIMEOUT(16'd16), .STOP_ON_ERR(1'b1)) dut_a (
        .clk(clk), .reset(rst), .tif(if_a), .state(st_a), .fail_code(fc_a),
        .err_cnt(ec_a), .commit_cnt(cc_a), .mism_pc(mp_a), .mism_got(mg_a), .mism_exp(me_a));

    trace_compare_unit #(.FIFO_DEPTH(8), .START_PC(START), .END_PC(ENDPC),
                         .TIMEOUT(16'd16), .STOP_ON_ERR(1'b0)) dut_b (
        .clk(clk), .reset(rst), .tif(if_b), .state(st_b), .fail_code(fc_b),
        .err_cnt(ec_b), .commit_cnt(cc_b), .mism_pc(mp_b), .mism_got(mg_b), .mism_exp(me_b));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: two instances (index 0 stops on error, index 1 keeps going).
    rec_t        mq0[$];
    rec_t        mq1[$];
    int          m_st[2];
    int          m_idle[2];
    logic [15:0] m_err[2];
    logic [1:0]  m_fc[2];
    logic [31:0] m_cc[2], m_mp[2], m_mg[2], m_me[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_idle[m] = 0; m_err[m] = 0; m_fc[m] = 0;
            m_cc[m] = 0; m_mp[m] = 0; m_mg[m] = 0; m_me[m] = 0;
        end
        mq0.delete();
        mq1.delete();
    endtask

    task automatic model_step(input int m, output bit rdy);
        rec_t        h, n;
        int          sz;
        logic [1:0]  code;
        logic [31:0] expd, mask;
        sz   = (m == 0) ? mq0.size() : mq1.size();
        rdy  = (m_st[m] < 2) && (sz < 8);
        code = 0;
        expd = 0;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        if (m_st[m] == 1 && we != 0 && wnum != 0) begin
            m_cc[m]++;
            m_idle[m] = 0;
            if (sz == 0) begin
                code = 2;
            end else begin
                if (m == 0) h = mq0.pop_front();
                else        h = mq1.pop_front();
                if (pc != h.pc || wnum != h.wnum || ((wdata ^ h.wdata) & mask) != 0) begin
                    code = 1;
                    expd = h.wdata;
                end
            end
        end else if (m_st[m] == 1) begin
            m_idle[m]++;
            if (m_idle[m] == 16) code = 3;
        end
        if (rv && rdy) begin
            n.pc = rpc; n.wnum = rwnum; n.wdata = rwdata;
            if (m == 0) mq0.push_back(n);
            else        mq1.push_back(n);
        end
        if (code != 0) begin
            if (m_err[m] != 16'hffff) m_err[m]++;
            if (m_fc[m] == 0) begin
                m_fc[m] = code; m_mp[m] = pc; m_mg[m] = wdata; m_me[m] = expd;
            end
        end
        if (m_st[m] == 0) begin
            if (pc == START) m_st[m] = 1;
        end else if (m_st[m] == 1) begin
            if (code == 3 || (code != 0 && m == 0)) m_st[m] = 3;
            else if (pc == ENDPC) m_st[m] = (m_err[m] == 0) ? 2 : 3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pc = 0; we = 0; wnum = 0; wdata = 0;
        rv = 0; rpc = 0; rwnum = 0; rwdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [4:0] n, input logic [31:0] d);
        rv = 1'b1; rpc = p; rwnum = n; rwdata = d;
        tick();
        rv = 1'b0;
    endtask

    task automatic commit(input logic [31:0] p, input logic [3:0] w, input logic [4:0] n,
                          input logic [31:0] d);
        pc = p; we = w; wnum = n; wdata = d;
        tick();
        pc = 0; we = 0; wnum = 0; wdata = 0;
    endtask

    task automatic go_run();
        pc = START;
        tick();
        pc = 0;
    endtask

    function automatic rec_t frec(input int i);
        rec_t r;
        r.pc    = 32'h1c00_1000 + 32'(4 * i);
        r.wnum  = 5'(i % 31 + 1);
        r.wdata = 32'ha500_0000 + 32'(i);
        return r;
    endfunction

    vec_t vt[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t r;
        bit   r0, r1;
        rst = 1'b1;
        idle_in();

        vt[0] = '{4'hf, 5'd3, 32'h1c000020, 32'hcafef00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd1, 2'd0, 32'd1};
        vt[1] = '{4'h3, 5'd3, 32'h1c000020, 32'h0000f00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd1, 2'd0, 32'd1};
        vt[2] = '{4'h1, 5'd3, 32'h1c000020, 32'hcafef00e, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd3, 2'd1, 32'd1};
        vt[3] = '{4'h4, 5'd3, 32'h1c000020, 32'hca00f00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd3, 2'd1, 32'd1};
        vt[4] = '{4'hf, 5'd3, 32'h1c000024, 32'hcafef00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd3, 2'd1, 32'd1};
        vt[5] = '{4'hf, 5'd4, 32'h1c000020, 32'hcafef00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd3, 2'd1, 32'd1};
        vt[6] = '{4'h0, 5'd3, 32'h1c000020, 32'hcafef00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd1, 2'd0, 32'd0};
        vt[7] = '{4'hf, 5'd0, 32'h1c000020, 32'hcafef00d, 32'h1c000020, 5'd3, 32'hcafef00d, 2'd1, 2'd0, 32'd0};

        // Reset state and a clean three-record run to PASS.
        do_reset();
        chk("rst_state", st_a, 0); chk("rst_fc", fc_a, 0); chk("rst_err", ec_a, 0);
        chk("rst_cc", cc_a, 0); chk("rst_mpc", mp_a, 0); chk("rst_ready", if_a.ref_ready, 1);
        push(32'h1c000004, 5'd1, 32'h11111111);
        push(32'h1c000008, 5'd2, 32'h22222222);
        push(32'h1c00000c, 5'd3, 32'h33333333);
        go_run();
        chk("run_state", st_a, 1);
        commit(32'h1c000004, 4'hf, 5'd1, 32'h11111111);
        commit(32'h1c000008, 4'hf, 5'd2, 32'h22222222);
        commit(32'h1c00000c, 4'hf, 5'd3, 32'h33333333);
        pc = ENDPC; tick(); pc = 0; #1;
        chk("pass_state", st_a, 2); chk("pass_err", ec_a, 0); chk("pass_cc", cc_a, 3);
        chk("pass_ready", if_a.ref_ready, 0); chk("pass_state_b", st_b, 2);

        // Table of single-commit vectors.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            push(vt[i].rpc, vt[i].rwnum, vt[i].rwdata);
            go_run();
            commit(vt[i].pc, vt[i].we, vt[i].wnum, vt[i].wdata);
            chk($sformatf("vec%0d_state", i), st_a, vt[i].exp_st);
            chk($sformatf("vec%0d_fc", i), fc_a, vt[i].exp_fc);
            chk($sformatf("vec%0d_cc", i), cc_a, vt[i].exp_cc);
            if (vt[i].exp_cc == 0) begin
                commit(vt[i].rpc, 4'hf, vt[i].rwnum, vt[i].rwdata);
                chk($sformatf("vec%0d_nopop_cc", i), cc_a, 1);
                chk($sformatf("vec%0d_nopop_fc", i), fc_a, 0);
            end
        end

        // Data mismatch capture.
        do_reset();
        push(32'h1c000004, 5'd5, 32'h12345678);
        go_run();
        commit(32'h1c000004, 4'hf, 5'd5, 32'h12345679);
        chk("mis_state", st_a, 3); chk("mis_fc", fc_a, 1); chk("mis_got", mg_a, 32'h12345679);
        chk("mis_exp", me_a, 32'h12345678); chk("mis_pc", mp_a, 32'h1c000004); chk("mis_err", ec_a, 1);

        // Underrun, with and without a same-cycle push.
        do_reset();
        go_run();
        commit(32'h1c000008, 4'hf, 5'd7, 32'hdeadbeef);
        chk("und_fc", fc_a, 2); chk("und_pc", mp_a, 32'h1c000008);
        chk("und_exp", me_a, 0); chk("und_got", mg_a, 32'hdeadbeef); chk("und_state", st_a, 3);
        do_reset();
        go_run();
        rv = 1'b1; rpc = 32'h1c000008; rwnum = 5'd7; rwdata = 32'hdeadbeef;
        commit(32'h1c000008, 4'hf, 5'd7, 32'hdeadbeef);
        rv = 1'b0;
        chk("und_bypass_fc", fc_a, 2);

        // Timeout after 16 commit-free RUN cycles, in both stop modes.
        do_reset();
        go_run();
        repeat (15) tick();
        chk("tmo_pre_state", st_a, 1);
        tick();
        chk("tmo_state", st_a, 3); chk("tmo_fc", fc_a, 3); chk("tmo_err", ec_a, 1);
        chk("tmo_state_b", st_b, 3); chk("tmo_fc_b", fc_b, 3);

        // Continue-on-error mode accumulates errors until END_PC.
        do_reset();
        push(32'h1c000004, 5'd1, 32'h11111111);
        push(32'h1c000008, 5'd2, 32'h22222222);
        push(32'h1c00000c, 5'd3, 32'h33333333);
        go_run();
        commit(32'h1c000004, 4'hf, 5'd1, 32'h11110000);
        commit(32'h1c000008, 4'hf, 5'd9, 32'h22222222);
        commit(32'h1c00000c, 4'hf, 5'd3, 32'h33333333);
        pc = ENDPC; tick(); pc = 0;
        chk("noerr_stop_err", ec_b, 2); chk("noerr_stop_state", st_b, 3);
        chk("noerr_stop_cc", cc_b, 3); chk("noerr_stop_fc", fc_b, 1);
        chk("noerr_stop_got", mg_b, 32'h11110000);
        chk("stop_state_a", st_a, 3); chk("stop_err_a", ec_a, 1); chk("stop_cc_a", cc_a, 1);

        // FIFO full behaviour and ordering across a rejected push.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r = frec(i);
            #1 chk($sformatf("fill%0d_ready", i), if_a.ref_ready, 1);
            push(r.pc, r.wnum, r.wdata);
        end
        #1 chk("full_ready", if_a.ref_ready, 0);
        go_run();
        r = frec(0);
        pc = r.pc; we = 4'hf; wnum = r.wnum; wdata = r.wdata;
        rv = 1'b1; rpc = 32'h1c0000f0; rwnum = 5'd9; rwdata = 32'hffffffff;
        #1 chk("full_pop_ready", if_a.ref_ready, 0);
        tick();
        rv = 1'b0;
        #1 chk("after_pop_ready", if_a.ref_ready, 1);
        r = frec(1);
        pc = r.pc; we = 4'hf; wnum = r.wnum; wdata = r.wdata;
        r = frec(8);
        rv = 1'b1; rpc = r.pc; rwnum = r.wnum; rwdata = r.wdata;
        tick();
        we = 4'h0; rv = 1'b0;
        #1 chk("pushpop_ready", if_a.ref_ready, 1);
        r = frec(9);
        push(r.pc, r.wnum, r.wdata);
        #1 chk("refull_ready", if_a.ref_ready, 0);
        for (int i = 2; i < 10; i++) begin
            r = frec(i);
            commit(r.pc, 4'hf, r.wnum, r.wdata);
        end
        chk("drain_state", st_a, 1); chk("drain_err", ec_a, 0); chk("drain_cc", cc_a, 10);
        commit(32'h1c002000, 4'hf, 5'd1, 32'h0);
        chk("drain_empty_fc", fc_a, 2);

        // Reset in the middle of RUN discards everything.
        do_reset();
        push(32'h1c000004, 5'd1, 32'h11111111);
        push(32'h1c000008, 5'd2, 32'h22222222);
        go_run();
        commit(32'h1c000004, 4'hf, 5'd1, 32'h11111111);
        chk("mid_cc", cc_a, 1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("mid_rst_state", st_a, 0); chk("mid_rst_cc", cc_a, 0);
        chk("mid_rst_err", ec_a, 0); chk("mid_rst_ready", if_a.ref_ready, 1);
        go_run();
        commit(32'h1c000008, 4'hf, 5'd2, 32'h22222222);
        chk("mid_rst_flushed_fc", fc_a, 2);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 80; cyc++) begin
                rv     = ($urandom % 3) != 0;
                rpc    = 32'h1c000004 + 32'(4 * ($urandom % 3));
                rwnum  = 5'($urandom % 3 + 1);
                rwdata = $urandom;
                we     = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
                if (mq1.size() > 0 && ($urandom % 8) != 0) begin
                    pc = mq1[0].pc; wnum = mq1[0].wnum; wdata = mq1[0].wdata;
                    if (($urandom % 10) == 0) wdata = wdata ^ (32'd1 << ($urandom % 32));
                end else begin
                    pc    = 32'h1c000004 + 32'(4 * ($urandom % 3));
                    wnum  = 5'($urandom % 4);
                    wdata = $urandom;
                end
                if (m_st[1] == 0 && ($urandom % 6) == 0) pc = START;
                if (m_st[1] == 1 && ($urandom % 50) == 0) pc = ENDPC;
                #1;
                model_step(0, r0);
                model_step(1, r1);
                chk("rnd_ready_a", if_a.ref_ready, r0);
                chk("rnd_ready_b", if_b.ref_ready, r1);
                tick();
                chk("rnd_state_a", st_a, m_st[0]);  chk("rnd_state_b", st_b, m_st[1]);
                chk("rnd_fc_a", fc_a, m_fc[0]);     chk("rnd_fc_b", fc_b, m_fc[1]);
                chk("rnd_err_a", ec_a, m_err[0]);   chk("rnd_err_b", ec_b, m_err[1]);
                chk("rnd_cc_a", cc_a, m_cc[0]);     chk("rnd_cc_b", cc_b, m_cc[1]);
                chk("rnd_mpc_a", mp_a, m_mp[0]);    chk("rnd_mpc_b", mp_b, m_mp[1]);
                chk("rnd_got_a", mg_a, m_mg[0]);    chk("rnd_got_b", mg_b, m_mg[1]);
                chk("rnd_exp_a", me_a, m_me[0]);    chk("rnd_exp_b", me_b, m_me[1]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
